// File: rtl/ov7670_cfg_sequencer_if.sv
// SCCB byte-write request channel between the config sequencer and the SCCB master.
interface ov7670_cfg_sequencer_if;
  logic       sccb_req;
  logic [7:0] sccb_dev_addr;
  logic [7:0] sccb_reg_addr;
  logic [7:0] sccb_reg_data;
  logic       sccb_busy;
  logic       sccb_done;
  logic       sccb_nack;

  modport master (
    output sccb_req, sccb_dev_addr, sccb_reg_addr, sccb_reg_data,
    input  sccb_busy, sccb_done, sccb_nack
  );

  modport slave (
    input  sccb_req, sccb_dev_addr, sccb_reg_addr, sccb_reg_data,
    output sccb_busy, sccb_done, sccb_nack
  );
endinterface

// File: rtl/ov7670_cfg_sequencer.sv
// OV7670 power-up configuration sequencer: walks a ROM register table and
// issues one SCCB write per entry, with power-up/marker delays and retries.
module ov7670_cfg_sequencer #(
  parameter int unsigned ROM_DEPTH      = 80,
  parameter int unsigned ROM_AW         = $clog2(ROM_DEPTH),
  parameter logic [7:0]  DEV_ADDR       = 8'h42,
  parameter int unsigned POWERUP_CYCLES = 300000,
  parameter int unsigned DELAY_CYCLES   = 100000,
  parameter int unsigned TIMEOUT_CYCLES = 65535,
  parameter int unsigned MAX_RETRY      = 3
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  output logic [ROM_AW-1:0]      rom_addr,
  input  logic [15:0]            rom_data,
  ov7670_cfg_sequencer_if.master sccb,
  output logic                   cfg_busy,
  output logic                   cfg_done,
  output logic                   cfg_error,
  output logic [ROM_AW-1:0]      wr_count
);

  localparam int unsigned CNT_MAX_PD = (POWERUP_CYCLES > DELAY_CYCLES) ? POWERUP_CYCLES : DELAY_CYCLES;
  localparam int unsigned CNT_MAX    = (CNT_MAX_PD > TIMEOUT_CYCLES) ? CNT_MAX_PD : TIMEOUT_CYCLES;
  localparam int unsigned CW         = $clog2(CNT_MAX + 1);
  localparam int unsigned RW         = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam logic [15:0] ENTRY_END  = 16'hFFFF;
  localparam logic [15:0] ENTRY_DLY  = 16'hFFF0;

  typedef enum logic [3:0] {
    S_POWERUP, S_FETCH, S_FETCH_WAIT, S_DECODE, S_ISSUE,
    S_WAIT_DONE, S_DELAY, S_DONE, S_ERROR
  } state_e;

  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [RW-1:0]     retry_q, retry_d;
  logic [ROM_AW-1:0] index_q, index_d;
  logic [ROM_AW-1:0] wr_cnt_q, wr_cnt_d;
  logic              req_q, req_d;
  logic [7:0]        reg_addr_q, reg_addr_d;
  logic [7:0]        reg_data_q, reg_data_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic [ROM_AW-1:0] index_inc;

  // The last table slot always terminates, so the index can never wrap.
  assign index_inc = (index_q == ROM_AW'(ROM_DEPTH - 1)) ? index_q : index_q + ROM_AW'(1);

  // Next-state, counters and registered-output values.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    retry_d    = retry_q;
    index_d    = index_q;
    wr_cnt_d   = wr_cnt_q;
    req_d      = 1'b0;
    reg_addr_d = reg_addr_q;
    reg_data_d = reg_data_q;

    case (state_q)
      S_POWERUP: begin
        if (cnt_q >= CW'(POWERUP_CYCLES - 1)) begin
          cnt_d   = '0;
          state_d = S_FETCH;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_FETCH:      state_d = S_FETCH_WAIT;
      S_FETCH_WAIT: state_d = S_DECODE;
      S_DECODE: begin
        if (rom_data == ENTRY_END || index_q == ROM_AW'(ROM_DEPTH - 1)) begin
          state_d = S_DONE;
        end else if (rom_data == ENTRY_DLY) begin
          cnt_d   = '0;
          state_d = S_DELAY;
        end else begin
          reg_addr_d = rom_data[15:8];
          reg_data_d = rom_data[7:0];
          retry_d    = '0;
          state_d    = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (!sccb.sccb_busy) begin
          req_d   = 1'b1;
          cnt_d   = '0;
          state_d = S_WAIT_DONE;
        end
      end
      S_WAIT_DONE: begin
        if (sccb.sccb_done && !sccb.sccb_nack) begin
          wr_cnt_d = wr_cnt_q + ROM_AW'(1);
          index_d  = index_inc;
          state_d  = S_FETCH;
        end else if (sccb.sccb_done || cnt_q >= CW'(TIMEOUT_CYCLES)) begin
          if (retry_q < RW'(MAX_RETRY)) begin
            retry_d = retry_q + RW'(1);
            state_d = S_ISSUE;
          end else begin
            state_d = S_ERROR;
          end
        end else if (cnt_q != CW'(CNT_MAX)) begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_DELAY: begin
        if (cnt_q >= CW'(DELAY_CYCLES - 1)) begin
          cnt_d   = '0;
          index_d = index_inc;
          state_d = S_FETCH;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_DONE, S_ERROR: begin
        if (start) begin
          cnt_d    = '0;
          index_d  = '0;
          wr_cnt_d = '0;
          state_d  = S_POWERUP;
        end
      end
      default: state_d = S_POWERUP;
    endcase

    busy_d = !(state_d == S_DONE || state_d == S_ERROR);
    done_d = (state_d == S_DONE);
    err_d  = (state_d == S_ERROR);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= S_POWERUP;
      cnt_q      <= '0;
      retry_q    <= '0;
      index_q    <= '0;
      wr_cnt_q   <= '0;
      req_q      <= 1'b0;
      reg_addr_q <= '0;
      reg_data_q <= '0;
      busy_q     <= 1'b1;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      retry_q    <= retry_d;
      index_q    <= index_d;
      wr_cnt_q   <= wr_cnt_d;
      req_q      <= req_d;
      reg_addr_q <= reg_addr_d;
      reg_data_q <= reg_data_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign rom_addr           = index_q;
  assign wr_count           = wr_cnt_q;
  assign cfg_busy           = busy_q;
  assign cfg_done           = done_q;
  assign cfg_error          = err_q;
  assign sccb.sccb_req      = req_q;
  assign sccb.sccb_dev_addr = DEV_ADDR;
  assign sccb.sccb_reg_addr = reg_addr_q;
  assign sccb.sccb_reg_data = reg_data_q;

endmodule

// File: tb/tb_ov7670_cfg_sequencer.sv
// Scoreboard bench for ov7670_cfg_sequencer: ROM model, SCCB master model,
// request/completion monitors fed by expectation queues.
module tb_ov7670_cfg_sequencer;
  localparam int unsigned DEPTH = 8;
  localparam int unsigned AW    = 3;
  localparam int unsigned PWR   = 10;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] rom_addr;
  logic [15:0]   rom_data = '0;
  logic          cfg_busy, cfg_done, cfg_error;
  logic [AW-1:0] wr_count;
  logic [15:0]   rom [DEPTH];

  logic mdl_busy = 1'b0, ext_busy = 1'b0, mdl_done = 1'b0, mdl_nack = 1'b0;
  int   nack_left = 0;
  bit   never_done = 1'b0;

  int          total = 0, bad = 0;
  int          cyc = 0, rel = 0, drop = 0;
  logic [15:0] exp_req[$];
  logic [7:0]  exp_cpl[$];
  int          req_cyc[$];
  logic        prev_req = 1'b0, prev_busy = 1'b1;

  ov7670_cfg_sequencer_if sccb ();
  assign sccb.sccb_busy = mdl_busy | ext_busy;
  assign sccb.sccb_done = mdl_done;
  assign sccb.sccb_nack = mdl_nack;

  ov7670_cfg_sequencer #(
    .ROM_DEPTH(DEPTH), .DEV_ADDR(8'h42), .POWERUP_CYCLES(PWR),
    .DELAY_CYCLES(5), .TIMEOUT_CYCLES(20), .MAX_RETRY(2)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .rom_addr(rom_addr),
    .rom_data(rom_data), .sccb(sccb), .cfg_busy(cfg_busy),
    .cfg_done(cfg_done), .cfg_error(cfg_error), .wr_count(wr_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) rom_data <= rom[rom_addr];

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  function automatic void chk_rng(string name, int act, int lo, int hi);
    total++;
    if (act < lo || act > hi) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
    end
  endfunction

  // SCCB master model: busy after a request, done ~8 cycles later.
  initial begin
    forever begin
      @(negedge clk);
      if (sccb.sccb_req && reset && !never_done) begin
        mdl_busy = 1'b1;
        repeat (7) @(negedge clk);
        mdl_done = 1'b1;
        mdl_nack = (nack_left > 0);
        if (nack_left > 0) nack_left--;
        @(negedge clk);
        mdl_done = 1'b0;
        mdl_nack = 1'b0;
        mdl_busy = 1'b0;
      end
    end
  end

  // Monitor: check requests and completions against the expectation queues.
  always @(negedge clk) begin
    if (reset) begin
      if (sccb.sccb_req) begin
        req_cyc.push_back(cyc);
        if (prev_req) chk("req_one_cycle", 1, 0);
        chk("dev_addr", 32'(sccb.sccb_dev_addr), 32'h42);
        if (exp_req.size() == 0) chk("unexpected_req", {sccb.sccb_reg_addr, sccb.sccb_reg_data}, 32'hDEAD);
        else chk("req_operands", {sccb.sccb_reg_addr, sccb.sccb_reg_data}, exp_req.pop_front());
      end
      if (prev_busy && !cfg_busy) begin
        if (exp_cpl.size() == 0) chk("unexpected_end", {cfg_done, cfg_error, wr_count, rom_addr}, 32'hDEAD);
        else chk("completion", {cfg_done, cfg_error, wr_count, rom_addr}, exp_cpl.pop_front());
      end
    end
    prev_req  = sccb.sccb_req;
    prev_busy = cfg_busy;
  end

  task automatic load_rom(input logic [15:0] e0, e1, e2, e3);
    for (int i = 0; i < DEPTH; i++) rom[i] = 16'hFFFF;
    rom[0] = e0; rom[1] = e1; rom[2] = e2; rom[3] = e3;
  endtask

  task automatic check_reset_vals();
    chk("rst_req", 32'(sccb.sccb_req), 0);
    chk("rst_busy", 32'(cfg_busy), 1);
    chk("rst_done_err", {cfg_done, cfg_error}, 0);
    chk("rst_wr_count", 32'(wr_count), 0);
    chk("rst_rom_addr", 32'(rom_addr), 0);
    chk("rst_operands", {sccb.sccb_reg_addr, sccb.sccb_reg_data}, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    rel = cyc;
    req_cyc.delete();
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    @(negedge clk);
    while (cfg_busy && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (cfg_busy) chk({name, "_timeout"}, 1, 0);
    repeat (2) @(negedge clk);
    chk({name, "_req_q_empty"}, 32'(exp_req.size()), 0);
    chk({name, "_cpl_q_empty"}, 32'(exp_cpl.size()), 0);
  endtask

  task automatic wait_req(input int n);
    int k = 0;
    while (req_cyc.size() < n && k < 500) begin
      @(negedge clk);
      k++;
    end
    if (req_cyc.size() < n) chk("wait_req_timeout", 1, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < DEPTH; i++) rom[i] = 16'hFFFF;
    repeat (2) @(negedge clk);
    check_reset_vals();

    // 1: table with a delay marker, all acked
    load_rom(16'h1280, 16'hFFF0, 16'h1100, 16'hFFFF);
    exp_req.push_back(16'h1280); exp_req.push_back(16'h1100);
    exp_cpl.push_back({1'b1, 1'b0, 3'd2, 3'd3});
    do_reset();
    wait_idle("basic");
    chk("basic_req_count", 32'(req_cyc.size()), 2);
    if (req_cyc.size() == 2) begin
      chk("first_req_latency", 32'(req_cyc[0] - rel), 32'(PWR + 4));
      chk_rng("delay_marker_gap", req_cyc[1] - req_cyc[0], 17, 24);
    end

    // 2: two NACKs then ack, sequence completes
    load_rom(16'h1280, 16'h1100, 16'hFFFF, 16'hFFFF);
    repeat (3) exp_req.push_back(16'h1280);
    exp_req.push_back(16'h1100);
    exp_cpl.push_back({1'b1, 1'b0, 3'd2, 3'd2});
    do_reset();
    nack_left = 2;
    wait_idle("retry_ok");

    // 3: three NACKs exhaust the retries
    exp_req.push_back(16'h1280); exp_req.push_back(16'h1280); exp_req.push_back(16'h1280);
    exp_cpl.push_back({1'b0, 1'b1, 3'd0, 3'd0});
    do_reset();
    nack_left = 3;
    wait_idle("nack_err");
    repeat (40) @(negedge clk);
    chk("nack_err_no_more_reqs", 32'(req_cyc.size()), 3);
    nack_left = 0;

    // 4: master never answers, timeouts exhaust the retries
    exp_req.push_back(16'h1280); exp_req.push_back(16'h1280); exp_req.push_back(16'h1280);
    exp_cpl.push_back({1'b0, 1'b1, 3'd0, 3'd0});
    never_done = 1'b1;
    do_reset();
    wait_idle("timeout_err");
    if (req_cyc.size() == 3) begin
      chk_rng("timeout_spacing_a", req_cyc[1] - req_cyc[0], 20, 24);
      chk_rng("timeout_spacing_b", req_cyc[2] - req_cyc[1], 20, 24);
    end else chk("timeout_req_count", 32'(req_cyc.size()), 3);
    never_done = 1'b0;

    // 5: busy held high while the entry waits in ISSUE
    load_rom(16'h1280, 16'hFFFF, 16'hFFFF, 16'hFFFF);
    exp_req.push_back(16'h1280);
    exp_cpl.push_back({1'b1, 1'b0, 3'd1, 3'd1});
    ext_busy = 1'b1;
    do_reset();
    repeat (PWR + 4 + 30) @(negedge clk);
    chk("busy_hold_no_req", 32'(req_cyc.size()), 0);
    ext_busy = 1'b0;
    drop = cyc;
    wait_idle("busy_hold");
    chk("busy_hold_req_count", 32'(req_cyc.size()), 1);
    if (req_cyc.size() == 1) chk("busy_release_to_req", 32'(req_cyc[0] - drop), 1);

    // 6: reset during WAIT_DONE abandons the transfer and restarts at entry 0
    load_rom(16'h1280, 16'h1100, 16'hFFFF, 16'hFFFF);
    exp_req.push_back(16'h1280);
    do_reset();
    wait_req(1);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_vals();
    exp_req.push_back(16'h1280); exp_req.push_back(16'h1100);
    exp_cpl.push_back({1'b1, 1'b0, 3'd2, 3'd2});
    reset = 1'b1;
    wait_idle("mid_reset");

    // 7/8: start after DONE reruns the table; start mid-sequence is ignored
    exp_req.push_back(16'h1280); exp_req.push_back(16'h1100);
    exp_cpl.push_back({1'b1, 1'b0, 3'd2, 3'd2});
    req_cyc.delete();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("start_clears", {cfg_busy, cfg_done, cfg_error, wr_count}, {1'b1, 1'b0, 1'b0, 3'd0});
    wait_req(1);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_idle("restart");
    chk("restart_req_count", 32'(req_cyc.size()), 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
